// File: rtl/mem_port_arbiter.sv
// Two-port arbiter and access sequencer for the shared MIPS32 memory bus.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise port 0 has fixed priority.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          busy,
  output logic          owner
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);

  if (WAIT_CYCLES < 1) begin : g_wait_check
    $error("mem_port_arbiter: WAIT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q, owner_q, busy_q, rd_q, wr_q, ack0_q, ack1_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata0_q, rdata1_q;
  logic          grant1_d;

`ifdef ARB_ROUND_ROBIN_EN
  // last_owner resets to 1 so that port 0 wins the first tie.
  logic last_owner_q;
  assign grant1_d = m1_req & (~m0_req | ~last_owner_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= 1'b1;
    end else if (state_q == RESP) begin
      last_owner_q <= owner_q;
    end
  end
`else
  assign grant1_d = m1_req & ~m0_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      owner_q  <= 1'b0;
      busy_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            state_q <= ACCESS;
            owner_q <= grant1_d;
            we_q    <= grant1_d ? m1_we : m0_we;
            addr_q  <= grant1_d ? m1_addr : m0_addr;
            wdata_q <= grant1_d ? m1_wdata : m0_wdata;
            rd_q    <= grant1_d ? ~m1_we : ~m0_we;
            wr_q    <= grant1_d ? m1_we : m0_we;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(WAIT_CYCLES - 1);
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            // Last strobe cycle: read data is sampled while mem_rd is still high.
            state_q <= RESP;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            if (!we_q) begin
              if (owner_q) rdata1_q <= mem_rdata;
              else         rdata0_q <= mem_rdata;
            end
            ack0_q <= ~owner_q;
            ack1_q <= owner_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        m0_ack, m1_ack, mem_rd, mem_wr, busy, owner;

  logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_m0_ack, b_m1_ack, b_mem_rd, b_mem_wr, b_busy, b_owner;

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_last;
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] model_mem(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  assign mem_rdata   = model_mem(mem_addr);
  assign b_mem_rdata = model_mem(b_mem_addr);

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .busy(b_busy), .owner(b_owner)
  );

  // Arbitration rule: a lone requester wins; ties follow the configured policy.
  function automatic int model_winner(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (exp_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  task automatic step;
    @(negedge clk);
  endtask

  task automatic model_reset;
    exp_last  = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step;
    n_cmp++;
    if ({mem_rd, mem_wr, m0_ack, m1_ack, busy, owner} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: rd/wr/ack0/ack1/busy/owner=%b want 000000",
               {mem_rd, mem_wr, m0_ack, m1_ack, busy, owner});
    end
    n_cmp++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mem: addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
    end
    n_cmp++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rdata: m0=%h m1=%h want 0/0", m0_rdata, m1_rdata);
    end
    n_cmp++;
    if ({b_busy, b_mem_rd, b_mem_wr, b_m0_ack} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_b: busy/rd/wr/ack=%b want 0000", {b_busy, b_mem_rd, b_mem_wr, b_m0_ack});
    end
    rst = 1'b0;
    model_reset();
    step;
    $display("txn reset done");
  endtask

  task automatic test_single_read;
    m0_we = 1'b0; m0_addr = 32'h40; m0_req = 1'b1;
    for (int c = 1; c <= W; c++) begin
      step;
      n_cmp++;
      if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h40 || busy !== 1'b1 ||
          owner !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
        n_err++;
        $display("FAIL read_access c%0d: rd=%b wr=%b addr=%h busy=%b owner=%b acks=%b%b want 1 0 00000040 1 0 00",
                 c, mem_rd, mem_wr, mem_addr, busy, owner, m0_ack, m1_ack);
      end
    end
    step;
    n_cmp++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || mem_rd !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL read_ack: ack0=%b ack1=%b rd=%b rdata=%h want 1 0 0 deadbeef",
               m0_ack, m1_ack, mem_rd, m0_rdata);
    end
    m0_req = 1'b0;
    exp_rd[0] = 32'hDEADBEEF; exp_last = 0;
    step;
    n_cmp++;
    if (busy !== 1'b0 || m0_ack !== 1'b0) begin
      n_err++;
      $display("FAIL read_idle: busy=%b ack0=%b want 0 0", busy, m0_ack);
    end
    $display("txn read m0 addr=00000040 data=%h", m0_rdata);
  endtask

  task automatic test_single_write;
    m1_we = 1'b1; m1_addr = 32'h100; m1_wdata = 32'h12345678; m1_req = 1'b1;
    for (int c = 1; c <= W; c++) begin
      step;
      n_cmp++;
      if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h100 ||
          mem_wdata !== 32'h12345678 || owner !== 1'b1 || m1_ack !== 1'b0) begin
        n_err++;
        $display("FAIL write_access c%0d: wr=%b rd=%b addr=%h wdata=%h owner=%b ack1=%b want 1 0 00000100 12345678 1 0",
                 c, mem_wr, mem_rd, mem_addr, mem_wdata, owner, m1_ack);
      end
    end
    step;
    n_cmp++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || mem_wr !== 1'b0 ||
        m1_rdata !== exp_rd[1] || m0_rdata !== exp_rd[0]) begin
      n_err++;
      $display("FAIL write_ack: ack1=%b ack0=%b wr=%b rd1=%h rd0=%h want 1 0 0 %h %h",
               m1_ack, m0_ack, mem_wr, m1_rdata, m0_rdata, exp_rd[1], exp_rd[0]);
    end
    m1_req = 1'b0; m1_we = 1'b0;
    exp_last = 1;
    step;
    $display("txn write m1 addr=00000100 data=12345678");
  endtask

  task automatic test_contention;
    int k, got, exp_w;
    rst = 1'b1; step; rst = 1'b0; model_reset();
    m0_we = 1'b0; m0_addr = 32'h500; m1_we = 1'b0; m1_addr = 32'h600;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_w = model_winner(1'b1, 1'b1);
      k = 0;
      step;
      while (!(m0_ack || m1_ack) && k < 20) begin
        step; k++;
      end
      got = m1_ack ? 1 : 0;
      exp_rd[exp_w] = model_mem(exp_w ? 32'h600 : 32'h500);
      n_cmp++;
      if (k >= 20 || got != exp_w || (m0_ack && m1_ack) ||
          m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
        n_err++;
        $display("FAIL contention t%0d: winner=%0d acks=%b%b rd0=%h rd1=%h waited=%0d want winner=%0d rd0=%h rd1=%h",
                 t, got, m0_ack, m1_ack, m0_rdata, m1_rdata, k, exp_w, exp_rd[0], exp_rd[1]);
      end
      $display("txn contention %0d granted m%0d", t, got);
      exp_last = exp_w;
      if (t == 3) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
    end
    step;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL contention_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_input_change;
    m0_we = 1'b0; m0_addr = 32'h40; m0_req = 1'b1;
    step;
    m0_addr = 32'h80; m0_we = 1'b1; m0_wdata = $urandom;
    step;
    n_cmp++;
    if (mem_addr !== 32'h40 || mem_rd !== 1'b1 || mem_wr !== 1'b0) begin
      n_err++;
      $display("FAIL change_access: addr=%h rd=%b wr=%b want 00000040 1 0", mem_addr, mem_rd, mem_wr);
    end
    step;
    n_cmp++;
    if (mem_addr !== 32'h40 || m0_ack !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL change_resp: addr=%h ack0=%b rd0=%h want 00000040 1 deadbeef", mem_addr, m0_ack, m0_rdata);
    end
    m0_req = 1'b0; m0_we = 1'b0;
    exp_rd[0] = 32'hDEADBEEF; exp_last = 0;
    step;
    $display("txn input-change m0 addr held at %h", mem_addr);
  endtask

  task automatic test_reset_mid;
    logic seen_ack;
    m0_we = 1'b0; m0_addr = 32'h200; m0_req = 1'b1;
    step;
    n_cmp++;
    if (mem_rd !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_start: rd=%b want 1", mem_rd);
    end
    rst = 1'b1;
    step;
    n_cmp++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_abort: rd=%b wr=%b busy=%b want 0 0 0", mem_rd, mem_wr, busy);
    end
    rst = 1'b0; m0_req = 1'b0; model_reset();
    seen_ack = 1'b0;
    repeat (6) begin
      step;
      if (m0_ack || m1_ack || busy) seen_ack = 1'b1;
    end
    n_cmp++;
    if (seen_ack !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_noack: activity=%b want 0", seen_ack);
    end
    m1_we = 1'b0; m1_addr = 32'h300; m1_req = 1'b1;
    repeat (W + 1) step;
    n_cmp++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || m1_rdata !== model_mem(32'h300) || m0_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_m1: ack1=%b ack0=%b rd1=%h rd0=%h want 1 0 %h 00000000",
               m1_ack, m0_ack, m1_rdata, m0_rdata, model_mem(32'h300));
    end
    m1_req = 1'b0;
    exp_rd[1] = model_mem(32'h300); exp_last = 1;
    step;
    $display("txn post-reset m1 read data=%h", m1_rdata);
    rst = 1'b1; step; rst = 1'b0; model_reset();
    m0_addr = 32'h40; m0_req = 1'b1; m1_req = 1'b1;
    step;
    n_cmp++;
    if (owner !== 1'(model_winner(1'b1, 1'b1)) || mem_addr !== 32'h40) begin
      n_err++;
      $display("FAIL rstmid_tie_owner: owner=%b addr=%h want %0d 00000040",
               owner, mem_addr, model_winner(1'b1, 1'b1));
    end
    repeat (W) step;
    n_cmp++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_tie_ack: ack0=%b ack1=%b want 1 0", m0_ack, m1_ack);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    exp_rd[0] = 32'hDEADBEEF; exp_last = 0;
    step;
    $display("txn post-reset tie granted m0");
  endtask

  task automatic test_back_to_back;
    logic exp_ack, exp_busy;
    b_m0_we = 1'b0; b_m0_addr = 32'h1234; b_m0_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step;
      exp_ack  = (c % 3 == 2);
      exp_busy = (c % 3 != 0);
      n_cmp++;
      if (b_m0_ack !== exp_ack || b_busy !== exp_busy || b_m1_ack !== 1'b0 ||
          (exp_ack && b_m0_rdata !== model_mem(32'h1234))) begin
        n_err++;
        $display("FAIL b2b c%0d: ack=%b busy=%b ack1=%b rdata=%h want %b %b 0 %h",
                 c, b_m0_ack, b_busy, b_m1_ack, b_m0_rdata, exp_ack, exp_busy, model_mem(32'h1234));
      end
      if (exp_ack) $display("txn b2b ack at cycle %0d", c);
    end
    b_m0_req = 1'b0;
    step;
  endtask

  task automatic test_random;
    logic        pend [2];
    logic        pwe  [2];
    logic [31:0] pad  [2];
    logic [31:0] pwd  [2];
    int          w;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(2) != 0)) begin
          pend[p] = 1'b1;
          pwe[p]  = 1'($urandom_range(1));
          pad[p]  = $urandom;
          pwd[p]  = $urandom;
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[1] = 1'b1; pwe[1] = 1'b0; pad[1] = $urandom; pwd[1] = $urandom;
      end
      m0_req = pend[0]; m0_we = pwe[0]; m0_addr = pad[0]; m0_wdata = pwd[0];
      m1_req = pend[1]; m1_we = pwe[1]; m1_addr = pad[1]; m1_wdata = pwd[1];
      w = model_winner(pend[0], pend[1]);
      for (int c = 1; c <= W; c++) begin
        step;
        n_cmp++;
        if (mem_rd !== ~pwe[w] || mem_wr !== pwe[w] || mem_addr !== pad[w] ||
            mem_wdata !== pwd[w] || owner !== 1'(w) || busy !== 1'b1 || m0_ack || m1_ack) begin
          n_err++;
          $display("FAIL rand_access t%0d c%0d: rd=%b wr=%b addr=%h wdata=%h owner=%b want %b %b %h %h %0d",
                   t, c, mem_rd, mem_wr, mem_addr, mem_wdata, owner, ~pwe[w], pwe[w], pad[w], pwd[w], w);
        end
      end
      step;
      if (!pwe[w]) exp_rd[w] = model_mem(pad[w]);
      n_cmp++;
      if (m0_ack !== (w == 0) || m1_ack !== (w == 1) ||
          m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
        n_err++;
        $display("FAIL rand_resp t%0d: acks=%b%b rd0=%h rd1=%h want winner=%0d rd0=%h rd1=%h",
                 t, m0_ack, m1_ack, m0_rdata, m1_rdata, w, exp_rd[0], exp_rd[1]);
      end
      $display("txn rand %0d m%0d %s addr=%h", t, w, pwe[w] ? "wr" : "rd", pad[w]);
      exp_last = w;
      pend[w] = 1'b0;
      m0_req = pend[0]; m1_req = pend[1];
      step;
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL rand_idle t%0d: busy=%b want 0", t, busy);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (W + 3) step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
    model_reset();
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_input_change();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
